uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_counter.sv | 36 +++
 rtl/uart_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_rx.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, parity mode
// constants and the parity-error decision helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_EVEN     = 2'b10;
    // Any mode with bit 0 set is odd parity (2'b01 and 2'b11).
    localparam logic [1:0] PAR_ODD_MASK = 2'b01;

    // x is the XOR of all valid data bits and the received parity bit.
    function automatic logic parity_error(input logic [1:0] mode, input logic x);
        if ((mode & PAR_ODD_MASK) != PAR_NONE) begin
            return ~x;
        end
        return x;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-timing counter for the UART receiver.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   clear - hold the count at zero
//   half  - 1: tick after CLKS_PER_BIT/2 cycles, 0: after CLKS_PER_BIT cycles
//   tick  - one-cycle strobe at the sample point; the count restarts on it
module uart_baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic half,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [CNT_W-1:0] count;

    // Decoded from the count register so the FSM sees the strobe on the sample cycle.
    assign tick = (count == (half ? HALF_LAST : FULL_LAST));

    // Free-running interval counter, restarted by clear or its own tick.
    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing with mid-bit sampling,
// 7 or 8 data bits, none/odd/even parity, framing and parity error flags.
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset
//   rx          - serial line, idles high
//   data_length - 1: 8 data bits, 0: 7 data bits (latched at start of frame)
//   parity_type - 00 none, x1 odd, 10 even (latched at start of frame)
//   data_out    - received word, bit 7 is 0 for 7-bit frames
//   data_valid  - one-cycle pulse, one clock after the stop-bit sample
//   parity_err  - parity mismatch for the word marked by data_valid
//   frame_err   - stop bit was low for the word marked by data_valid
//   busy        - receiver is inside a frame
// Build option: define UART_RX_SYNC_EN to pass rx through a 2-flop
// synchronizer (adds 2 clocks to every sample point and to data_valid).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       data_length,
    input  logic [1:0] parity_type,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    uart_state_t state;
    logic        rx_s;
    logic        tick;
    logic        cnt_clear;
    logic        cnt_half;
    logic [2:0]  bit_cnt;
    logic        len8_q;
    logic [1:0]  par_q;
    logic [7:0]  shift_q;
    logic        par_acc;
    logic        perr_q;
    logic        valid_pend;

`ifdef UART_RX_SYNC_EN
    logic [1:0] rx_sync;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rx};
        end
    end

    assign rx_s = rx_sync[1];
`else
    assign rx_s = rx;
`endif

    // Counter idles at zero so START measures half a bit from the falling edge.
    assign cnt_clear = (state == IDLE);
    assign cnt_half  = (state == START);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .half  (cnt_half),
        .tick  (tick)
    );

    // Frame FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            len8_q     <= 1'b1;
            par_q      <= PAR_NONE;
            shift_q    <= 8'h00;
            par_acc    <= 1'b0;
            perr_q     <= 1'b0;
            valid_pend <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Pulse lags the stop sample by one clock.
            data_valid <= valid_pend;
            valid_pend <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        busy    <= 1'b1;
                        bit_cnt <= 3'd0;
                        len8_q  <= data_length;
                        par_q   <= parity_type;
                        par_acc <= 1'b0;
                        perr_q  <= 1'b0;
                    end
                end

                START: begin
                    if (tick) begin
                        if (rx_s) begin
                            // Glitch, not a start bit.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        par_acc <= par_acc ^ rx_s;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == (len8_q ? 3'd7 : 3'd6)) begin
                            state <= (par_q == PAR_NONE) ? STOP : PARITY;
                        end
                    end
                end

                PARITY: begin
                    if (tick) begin
                        perr_q <= parity_error(par_q, par_acc ^ rx_s);
                        state  <= STOP;
                    end
                end

                STOP: begin
                    if (tick) begin
                        // A 7-bit word sits in shift_q[7:1] after seven shifts.
                        data_out   <= len8_q ? shift_q : {1'b0, shift_q[7:1]};
                        parity_err <= (par_q == PAR_NONE) ? 1'b0 : perr_q;
                        frame_err  <= ~rx_s;
                        valid_pend <= 1'b1;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with CLKS_PER_BIT = 4.
module tb_uart_rx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       data_length;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int start_cyc = 0;

    logic [7:0] cap_data[$];
    int         cap_cyc[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .data_length (data_length),
        .parity_type (parity_type),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every data_valid pulse and the cycle it was seen in.
    always @(negedge clk) begin
        if (data_valid) begin
            cap_data.push_back(data_out);
            cap_cyc.push_back(cyc);
        end
    end

    // Called at a negedge; drives one frame, each bit held CPB clocks.
    task automatic send_frame(input logic [7:0] d, input logic len8, input logic [1:0] pt,
                              input logic pbit, input logic sbit, input bit flip);
        data_length = len8;
        parity_type = pt;
        rx = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(negedge clk);
        if (flip) begin
            data_length = ~len8;
            parity_type = 2'b11;
        end
        for (int i = 0; i < (len8 ? 8 : 7); i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        if (pt != 2'b00) begin
            rx = pbit;
            repeat (CPB) @(negedge clk);
        end
        rx = sbit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic clear_caps();
        cap_data.delete();
        cap_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx = 1'b1;
        data_length = 1'b1;
        parity_type = 2'b00;
        repeat (3) @(negedge clk);
        vectors++;
        if ({data_out, data_valid, parity_err, frame_err, busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got data=%h v=%b p=%b f=%b busy=%b want all zero",
                     data_out, data_valid, parity_err, frame_err, busy);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_8n1();
        int lat;
        clear_caps();
        send_frame(8'hA5, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        vectors++;
        if (cap_data.size() !== 1) begin
            errors++;
            $display("FAIL a5_pulses got %0d want 1", cap_data.size());
        end
        vectors++;
        if (data_out !== 8'hA5) begin
            errors++;
            $display("FAIL a5_data got %h want a5", data_out);
        end
        vectors++;
        if ({parity_err, frame_err} !== 2'b00) begin
            errors++;
            $display("FAIL a5_flags got p=%b f=%b want 0 0", parity_err, frame_err);
        end
        lat = (cap_cyc.size() > 0) ? cap_cyc[0] - start_cyc : -1;
        vectors++;
        if (lat !== 40) begin
            errors++;
            $display("FAIL a5_latency got %0d want 40", lat);
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL a5_busy got %b want 0", busy);
        end
    endtask

    task automatic test_even_parity_7bit();
        int lat;
        clear_caps();
        send_frame(8'h55, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        vectors++;
        if (data_out !== 8'h55) begin
            errors++;
            $display("FAIL e7_data got %h want 55", data_out);
        end
        vectors++;
        if ({parity_err, frame_err} !== 2'b10) begin
            errors++;
            $display("FAIL e7_flags got p=%b f=%b want 1 0", parity_err, frame_err);
        end
        lat = (cap_cyc.size() > 0) ? cap_cyc[0] - start_cyc : -1;
        vectors++;
        if (lat !== 40) begin
            errors++;
            $display("FAIL e7_latency got %0d want 40", lat);
        end
        // 7-bit word with the top data bit set: bit 7 of data_out must stay 0.
        clear_caps();
        send_frame(8'hC1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        vectors++;
        if (data_out !== 8'h41) begin
            errors++;
            $display("FAIL n7_data got %h want 41", data_out);
        end
        vectors++;
        if (cap_data.size() !== 1) begin
            errors++;
            $display("FAIL n7_pulses got %0d want 1", cap_data.size());
        end
    endtask

    task automatic test_odd_parity_frame_err();
        int lat;
        clear_caps();
        send_frame(8'h03, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        vectors++;
        if ({data_out, parity_err, frame_err} !== {8'h03, 2'b00}) begin
            errors++;
            $display("FAIL o8_word got data=%h p=%b f=%b want 03 0 0", data_out, parity_err, frame_err);
        end
        lat = (cap_cyc.size() > 0) ? cap_cyc[0] - start_cyc : -1;
        vectors++;
        if (lat !== 44) begin
            errors++;
            $display("FAIL o8_latency got %0d want 44", lat);
        end
        clear_caps();
        send_frame(8'h03, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        vectors++;
        if (cap_data.size() !== 1) begin
            errors++;
            $display("FAIL o8_ferr_pulses got %0d want 1", cap_data.size());
        end
        vectors++;
        if ({data_out, parity_err, frame_err} !== {8'h03, 2'b01}) begin
            errors++;
            $display("FAIL o8_ferr_word got data=%h p=%b f=%b want 03 0 1", data_out, parity_err, frame_err);
        end
        // Odd parity with a wrong parity bit.
        clear_caps();
        send_frame(8'h07, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        vectors++;
        if ({data_out, parity_err, frame_err} !== {8'h07, 2'b10}) begin
            errors++;
            $display("FAIL o8_bad_par got data=%h p=%b f=%b want 07 1 0", data_out, parity_err, frame_err);
        end
    endtask

    task automatic test_false_start();
        clear_caps();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL fs_busy_high got %b want 1", busy);
        end
        repeat (6) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fs_busy_low got %b want 0", busy);
        end
        vectors++;
        if (cap_data.size() !== 0) begin
            errors++;
            $display("FAIL fs_pulses got %0d want 0", cap_data.size());
        end
        vectors++;
        if ({data_out, parity_err, frame_err} !== {8'h07, 2'b10}) begin
            errors++;
            $display("FAIL fs_hold got data=%h p=%b f=%b want 07 1 0", data_out, parity_err, frame_err);
        end
    endtask

    task automatic test_reset_abort();
        clear_caps();
        data_length = 1'b1;
        parity_type = 2'b00;
        // Start bit plus data bits 0..2 of 8'hFF, then into bit 3.
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB + 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        vectors++;
        if (cap_data.size() !== 0) begin
            errors++;
            $display("FAIL abort_pulses got %0d want 0", cap_data.size());
        end
        vectors++;
        if ({data_out, parity_err, frame_err, busy} !== 11'h000) begin
            errors++;
            $display("FAIL abort_state got data=%h p=%b f=%b busy=%b want 00 0 0 0",
                     data_out, parity_err, frame_err, busy);
        end
        send_frame(8'h3C, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        vectors++;
        if (data_out !== 8'h3C) begin
            errors++;
            $display("FAIL abort_resume got %h want 3c", data_out);
        end
        vectors++;
        if (cap_data.size() !== 1) begin
            errors++;
            $display("FAIL abort_resume_pulses got %0d want 1", cap_data.size());
        end
    endtask

    task automatic test_config_latch();
        int lat;
        clear_caps();
        send_frame(8'hDA, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        vectors++;
        if ({data_out, parity_err, frame_err} !== {8'hDA, 2'b00}) begin
            errors++;
            $display("FAIL latch_word got data=%h p=%b f=%b want da 0 0", data_out, parity_err, frame_err);
        end
        lat = (cap_cyc.size() > 0) ? cap_cyc[0] - start_cyc : -1;
        vectors++;
        if (lat !== 40) begin
            errors++;
            $display("FAIL latch_latency got %0d want 40", lat);
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        int d0;
        int d1;
        int gap;
        clear_caps();
        send_frame(8'h11, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        s0 = start_cyc;
        send_frame(8'hEE, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        vectors++;
        if (cap_data.size() !== 2) begin
            errors++;
            $display("FAIL b2b_pulses got %0d want 2", cap_data.size());
        end
        d0  = (cap_data.size() > 0) ? int'(cap_data[0]) : -1;
        d1  = (cap_data.size() > 1) ? int'(cap_data[1]) : -1;
        gap = (cap_cyc.size() > 1) ? cap_cyc[1] - cap_cyc[0] : -1;
        vectors++;
        if (d0 !== 32'h11) begin
            errors++;
            $display("FAIL b2b_first got %0h want 11", d0);
        end
        vectors++;
        if (d1 !== 32'hEE) begin
            errors++;
            $display("FAIL b2b_second got %0h want ee", d1);
        end
        vectors++;
        if (gap !== 40) begin
            errors++;
            $display("FAIL b2b_gap got %0d want 40", gap);
        end
        vectors++;
        if (start_cyc - s0 !== 40) begin
            errors++;
            $display("FAIL b2b_start_spacing got %0d want 40", start_cyc - s0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_even_parity_7bit();
        test_odd_parity_frame_err();
        test_false_start();
        test_reset_abort();
        test_config_latch();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
